// File: rtl/gray_sync_decoder_if.sv
// rtl/gray_sync_decoder_if.sv - port bundle between a Gray-count consumer and gray_sync_decoder
interface gray_sync_decoder_if #(
  parameter int N = 8
);
  logic [N-1:0] gray_in;
  logic         err_clr;
  logic [N-1:0] bin_out;
  logic         bin_valid;
  logic [N-1:0] delta;
  logic         err;
  logic         err_sticky;

  modport master (
    output gray_in, err_clr,
    input  bin_out, bin_valid, delta, err, err_sticky
  );

  modport slave (
    input  gray_in, err_clr,
    output bin_out, bin_valid, delta, err, err_sticky
  );
endinterface

// File: rtl/gray_sync_decoder.sv
// rtl/gray_sync_decoder.sv - synchronizes and decodes a Gray count; GRAY_SYNC_ERRCHK_EN enables the multi-bit transition checker
module gray_sync_decoder #(
  parameter int N           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  gray_sync_decoder_if.slave  bus
);

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [N-1:0] sync_q [SYNC_STAGES];
  logic [N-1:0] sync_d [SYNC_STAGES];
  logic [N-1:0] g_prev_q, g_prev_d;
  logic [N-1:0] bin_out_q, bin_out_d;
  logic [N-1:0] delta_q, delta_d;
  logic         bin_valid_q, bin_valid_d;
  logic [N-1:0] gs;
  logic [N-1:0] gs_bin;
  logic [N-1:0] gs_diff;
  logic         accept;

  // Plain shift chain; nothing combinational between stages so each flop can resolve metastability
  always_comb begin
    sync_d[0] = bus.gray_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q <= sync_d;
    end
  end

  // Accept any new synchronized value; delta is the modular step from the last accepted value
  always_comb begin
    gs          = sync_q[SYNC_STAGES-1];
    gs_bin      = gray2bin(gs);
    gs_diff     = gs ^ g_prev_q;
    accept      = (gs != g_prev_q);
    g_prev_d    = g_prev_q;
    bin_out_d   = bin_out_q;
    delta_d     = delta_q;
    bin_valid_d = 1'b0;
    if (accept) begin
      g_prev_d    = gs;
      bin_out_d   = gs_bin;
      delta_d     = gs_bin - bin_out_q;
      bin_valid_d = 1'b1;
    end
  end

  // Decoder state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_prev_q    <= '0;
      bin_out_q   <= '0;
      delta_q     <= '0;
      bin_valid_q <= 1'b0;
    end else begin
      g_prev_q    <= g_prev_d;
      bin_out_q   <= bin_out_d;
      delta_q     <= delta_d;
      bin_valid_q <= bin_valid_d;
    end
  end

  assign bus.bin_out   = bin_out_q;
  assign bus.delta     = delta_q;
  assign bus.bin_valid = bin_valid_q;

`ifdef GRAY_SYNC_ERRCHK_EN
  logic err_q, err_d;
  logic err_sticky_q, err_sticky_d;
  logic multi_bit;

  // More than one bit set in the difference means the source skipped or the crossing tore a value;
  // a new error takes priority over a simultaneous clear so it is never lost
  always_comb begin
    multi_bit    = ((gs_diff & (gs_diff - N'(1))) != '0);
    err_d        = accept && multi_bit;
    err_sticky_d = err_sticky_q;
    if (err_d) begin
      err_sticky_d = 1'b1;
    end else if (bus.err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  // Error pulse and sticky flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.err        = err_q;
  assign bus.err_sticky = err_sticky_q;
`else
  logic unused_err_inputs;

  // Checker absent: clear input and transition difference have no consumer
  assign unused_err_inputs = bus.err_clr ^ (^gs_diff);
  assign bus.err           = 1'b0;
  assign bus.err_sticky    = 1'b0;
`endif

endmodule

// File: tb/tb_gray_sync_decoder.sv
// tb/tb_gray_sync_decoder.sv - directed self-checking bench for gray_sync_decoder
module tb_gray_sync_decoder;

  localparam int N = 8;
`ifdef GRAY_SYNC_ERRCHK_EN
  localparam logic ERRCHK = 1'b1;
`else
  localparam logic ERRCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  gray_sync_decoder_if #(.N(N)) bus ();

  gray_sync_decoder #(.N(N), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bin2gray(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.gray_in = 8'h00;
    bus.err_clr = 1'b0;
    repeat (3) tick();
    n_checks++; if (bus.bin_out !== 8'h00) begin n_fail++; $display("FAIL reset_bin_out: got %h want 00", bus.bin_out); end
    n_checks++; if (bus.delta !== 8'h00) begin n_fail++; $display("FAIL reset_delta: got %h want 00", bus.delta); end
    n_checks++; if (bus.bin_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.bin_valid); end
    n_checks++; if (bus.err !== 1'b0 || bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b/%b want 0/0", bus.err, bus.err_sticky); end
    rst = 1'b0;
    bus.gray_in = 8'h5A;
    repeat (6) tick();
    n_checks++; if (bus.bin_out !== 8'h6C) begin n_fail++; $display("FAIL pre_reset_bin_out: got %h want 6c", bus.bin_out); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.bin_out !== 8'h00 || bus.delta !== 8'h00) begin n_fail++; $display("FAIL async_reset_data: got %h/%h want 00/00", bus.bin_out, bus.delta); end
    n_checks++; if (bus.bin_valid !== 1'b0 || bus.err !== 1'b0 || bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got %b%b%b want 000", bus.bin_valid, bus.err, bus.err_sticky); end
    tick();
    rst = 1'b0;
    tick();
    n_checks++; if (bus.bin_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge1: valid got %b want 0", bus.bin_valid); end
    tick();
    n_checks++; if (bus.bin_valid !== 1'b0) begin n_fail++; $display("FAIL latency_edge2: valid got %b want 0", bus.bin_valid); end
    tick();
    n_checks++; if (bus.bin_valid !== 1'b1) begin n_fail++; $display("FAIL latency_edge3: valid got %b want 1", bus.bin_valid); end
    n_checks++; if (bus.bin_out !== 8'h6C || bus.delta !== 8'h6C) begin n_fail++; $display("FAIL after_reset_decode: got %h/%h want 6c/6c", bus.bin_out, bus.delta); end
    n_checks++; if (bus.err !== ERRCHK) begin n_fail++; $display("FAIL after_reset_err: got %b want %b", bus.err, ERRCHK); end
    tick();
    n_checks++; if (bus.bin_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse_width: got %b want 0", bus.bin_valid); end
  endtask

  task automatic test_full_count();
    logic [7:0] v;
    int pulses, errs, total;
    bus.gray_in = 8'h00;
    repeat (4) tick();
    n_checks++; if (bus.bin_out !== 8'h00 || bus.delta !== 8'h94) begin n_fail++; $display("FAIL count_start: got %h/%h want 00/94", bus.bin_out, bus.delta); end
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL count_clear: sticky got %b want 0", bus.err_sticky); end
    total = 0;
    for (int i = 1; i <= 256; i++) begin
      v = i[7:0];
      bus.gray_in = bin2gray(v);
      pulses = 0;
      errs = 0;
      for (int c = 0; c < 4; c++) begin
        tick();
        if (bus.bin_valid === 1'b1) pulses++;
        if (bus.err !== 1'b0) errs++;
      end
      total += pulses;
      n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL count_pulses[%0d]: got %0d want 1", i, pulses); end
      n_checks++; if (bus.bin_out !== v) begin n_fail++; $display("FAIL count_bin[%0d]: got %h want %h", i, bus.bin_out, v); end
      n_checks++; if (bus.delta !== 8'h01) begin n_fail++; $display("FAIL count_delta[%0d]: got %h want 01", i, bus.delta); end
      n_checks++; if (errs != 0) begin n_fail++; $display("FAIL count_err[%0d]: got %0d err pulses want 0", i, errs); end
    end
    n_checks++; if (total != 256) begin n_fail++; $display("FAIL count_total: got %0d pulses want 256", total); end
    n_checks++; if (bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL count_sticky: got %b want 0", bus.err_sticky); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_bin;
    bus.gray_in = bin2gray(8'd9);
    repeat (4) tick();
    n_checks++; if (bus.bin_out !== 8'd9 || bus.delta !== 8'd9) begin n_fail++; $display("FAIL b2b_start: got %h/%h want 09/09", bus.bin_out, bus.delta); end
    bus.gray_in = bin2gray(8'd10);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) bus.gray_in = bin2gray(8'd11);
      if (c == 2) bus.gray_in = bin2gray(8'd12);
      if (c >= 3 && c <= 5) begin
        exp_bin = 8'(7 + c);
        n_checks++; if (bus.bin_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b want 1", c, bus.bin_valid); end
        n_checks++; if (bus.bin_out !== exp_bin || bus.delta !== 8'd1) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h/%h want %h/01", c, bus.bin_out, bus.delta, exp_bin); end
      end else begin
        n_checks++; if (bus.bin_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: valid got %b want 0", c, bus.bin_valid); end
      end
    end
  endtask

  task automatic test_multi_bit();
    bus.gray_in = 8'h00;
    repeat (4) tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    n_checks++; if (bus.bin_out !== 8'h00 || bus.err_sticky !== 1'b0) begin n_fail++; $display("FAIL multi_start: got %h/%b want 00/0", bus.bin_out, bus.err_sticky); end
    bus.gray_in = 8'h03;
    tick();
    tick();
    n_checks++; if (bus.bin_valid !== 1'b0) begin n_fail++; $display("FAIL multi_early: valid got %b want 0", bus.bin_valid); end
    tick();
    n_checks++; if (bus.bin_valid !== 1'b1 || bus.bin_out !== 8'h02 || bus.delta !== 8'h02) begin n_fail++; $display("FAIL multi_data: got %b/%h/%h want 1/02/02", bus.bin_valid, bus.bin_out, bus.delta); end
    n_checks++; if (bus.err !== ERRCHK || bus.err_sticky !== ERRCHK) begin n_fail++; $display("FAIL multi_err: got %b/%b want %b/%b", bus.err, bus.err_sticky, ERRCHK, ERRCHK); end
    tick();
    n_checks++; if (bus.err !== 1'b0 || bus.err_sticky !== ERRCHK) begin n_fail++; $display("FAIL multi_after: got %b/%b want 0/%b", bus.err, bus.err_sticky, ERRCHK); end
  endtask

  task automatic test_clear_collision();
    bus.gray_in = 8'h00;
    tick();
    tick();
    bus.err_clr = 1'b1;
    tick();
    n_checks++; if (bus.bin_valid !== 1'b1 || bus.bin_out !== 8'h00 || bus.delta !== 8'hFE) begin n_fail++; $display("FAIL collide_data: got %b/%h/%h want 1/00/fe", bus.bin_valid, bus.bin_out, bus.delta); end
    n_checks++; if (bus.err !== ERRCHK || bus.err_sticky !== ERRCHK) begin n_fail++; $display("FAIL collide_set_wins: got %b/%b want %b/%b", bus.err, bus.err_sticky, ERRCHK, ERRCHK); end
    tick();
    bus.err_clr = 1'b0;
    n_checks++; if (bus.err_sticky !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL collide_clear: got %b/%b want 0/0", bus.err, bus.err_sticky); end
  endtask

  task automatic test_hold();
    int pulses, bad_bin, bad_delta;
    pulses = 0;
    bad_bin = 0;
    bad_delta = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.bin_valid !== 1'b0) pulses++;
      if (bus.bin_out !== 8'h00) bad_bin++;
      if (bus.delta !== 8'hFE) bad_delta++;
    end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL hold_valid: got %0d pulses want 0", pulses); end
    n_checks++; if (bad_bin != 0) begin n_fail++; $display("FAIL hold_bin: got %0d bad cycles want 0", bad_bin); end
    n_checks++; if (bad_delta != 0) begin n_fail++; $display("FAIL hold_delta: got %0d bad cycles want 0", bad_delta); end
  endtask

  initial begin
    test_reset();
    test_full_count();
    test_back_to_back();
    test_multi_bit();
    test_clear_collision();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
